// File: rtl/xmodem_scene_loader.sv
// Receive-side XMODEM (checksum) controller: buffers 128-byte blocks, verifies them and commits good ones to scene memory.
// Optional idle-timeout NAK resync is built when XM_TIMEOUT_EN is defined.
module xmodem_scene_loader #(
  parameter int ADDR_W      = 20,
  parameter int MAX_BYTES   = 20000,
  parameter int BLK_BYTES   = 128,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic              scene_loaded,
  output logic [ADDR_W-1:0] byte_count,
  output logic              overflow,
  output logic [7:0]        nak_count
);
  localparam int                IDX_W    = $clog2(BLK_BYTES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BLK_BYTES - 1);
  localparam logic [ADDR_W-1:0] MAX_A    = ADDR_W'(MAX_BYTES);
  localparam logic [7:0] SOH = 8'h01, EOT = 8'h04, ACK = 8'h06, NAK = 8'h15;

  typedef enum logic [3:0] {
    WAIT_SOH, BLK, BLKN, DATA, CKSUM, COMMIT, SEND_ACK, SEND_NAK, DONE
  } state_t;

  state_t            state;
  logic [7:0]        buffer [BLK_BYTES];
  logic [7:0]        blk, blkn, sum, expected;
  logic [IDX_W-1:0]  idx;
  logic              eot;

  logic [IDX_W-1:0]  idx_nxt, pres_idx;
  logic [ADDR_W-1:0] cnt_nxt, pres_addr;
  logic              pres_ok, frame_ok, is_dup, is_cur, commit_step;
  logic [7:0]        nak_inc;
  logic              timeout;

  assign idx_nxt     = idx + IDX_W'(1);
  assign cnt_nxt     = wr_en ? byte_count + ADDR_W'(1) : byte_count;
  assign frame_ok    = (blkn == ~blk) && (rx_data == sum);
  assign is_dup      = (blk == expected - 8'd1);
  assign is_cur      = (blk == expected);
  assign nak_inc     = (nak_count == 8'hFF) ? nak_count : nak_count + 8'd1;
  // A skipped (over-capacity) byte advances without a handshake.
  assign commit_step = !wr_en || wr_ready;

  // Next byte to present: first byte on entry from CKSUM, else the one after the current.
  always_comb begin
    pres_idx  = idx_nxt;
    pres_addr = cnt_nxt;
    if (state == CKSUM) begin
      pres_idx  = '0;
      pres_addr = byte_count;
    end
  end
  assign pres_ok = pres_addr < MAX_A;

  always_ff @(posedge clk)
    if (state == DATA && rx_valid) buffer[idx] <= rx_data;

`ifdef XM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] idle_cnt;
  logic            seen_soh, idle_run;

  assign idle_run = (state inside {BLK, BLKN, DATA, CKSUM}) || (state == WAIT_SOH && !seen_soh);
  assign timeout  = idle_run && !rx_valid && (idle_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      idle_cnt <= '0;
      seen_soh <= 1'b0;
    end else begin
      if (state == WAIT_SOH && rx_valid && rx_data == SOH) seen_soh <= 1'b1;
      if (rx_valid || !idle_run || timeout) idle_cnt <= '0;
      else                                  idle_cnt <= idle_cnt + TO_W'(1);
    end
  end
`else
  // No idle counter: the receive states wait indefinitely.
  assign timeout = 1'b0 && (TIMEOUT_CYC != 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state        <= WAIT_SOH;
      expected     <= 8'd1;
      blk          <= '0;
      blkn         <= '0;
      sum          <= '0;
      idx          <= '0;
      eot          <= 1'b0;
      tx_data      <= '0;
      tx_valid     <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      wr_en        <= 1'b0;
      scene_loaded <= 1'b0;
      byte_count   <= '0;
      overflow     <= 1'b0;
      nak_count    <= '0;
    end else if (timeout) begin
      state     <= SEND_NAK;
      tx_valid  <= 1'b1;
      tx_data   <= NAK;
      nak_count <= nak_inc;
    end else begin
      case (state)
        WAIT_SOH: if (rx_valid) begin
          if (rx_data == SOH) state <= BLK;
          else if (rx_data == EOT) begin
            eot      <= 1'b1;
            state    <= SEND_ACK;
            tx_valid <= 1'b1;
            tx_data  <= ACK;
          end
        end
        BLK: if (rx_valid) begin
          blk   <= rx_data;
          state <= BLKN;
        end
        BLKN: if (rx_valid) begin
          blkn  <= rx_data;
          idx   <= '0;
          sum   <= '0;
          state <= DATA;
        end
        DATA: if (rx_valid) begin
          sum <= sum + rx_data;
          idx <= idx_nxt;
          if (idx == LAST_IDX) state <= CKSUM;
        end
        CKSUM: if (rx_valid) begin
          if (frame_ok && is_dup) begin
            state    <= SEND_ACK;
            tx_valid <= 1'b1;
            tx_data  <= ACK;
          end else if (frame_ok && is_cur) begin
            state   <= COMMIT;
            idx     <= '0;
            wr_en   <= pres_ok;
            wr_addr <= pres_addr;
            wr_data <= buffer[pres_idx];
          end else begin
            state     <= SEND_NAK;
            tx_valid  <= 1'b1;
            tx_data   <= NAK;
            nak_count <= nak_inc;
          end
        end
        COMMIT: if (commit_step) begin
          if (wr_en) byte_count <= byte_count + ADDR_W'(1);
          else       overflow   <= 1'b1;
          if (idx == LAST_IDX) begin
            wr_en    <= 1'b0;
            expected <= expected + 8'd1;
            state    <= SEND_ACK;
            tx_valid <= 1'b1;
            tx_data  <= ACK;
          end else begin
            idx     <= idx_nxt;
            wr_en   <= pres_ok;
            wr_addr <= pres_addr;
            wr_data <= buffer[pres_idx];
          end
        end
        SEND_ACK, SEND_NAK: if (tx_ready) begin
          tx_valid <= 1'b0;
          if (eot) begin
            state        <= DONE;
            scene_loaded <= 1'b1;
          end else begin
            state <= WAIT_SOH;
          end
        end
        DONE: ;
        default: state <= WAIT_SOH;
      endcase
    end
  end
endmodule
